tff_updown_counter: RTL
=======================

# tff_updown_counter

Parametrised counter built from WIDTH toggle flip-flops. Each bit toggles under a per-bit T enable that is exported on the port, so the toggle pattern can be watched alongside the count. Beyond a plain 3-bit binary up-counter, the block adds:
- a configurable modulus;
- up/down direction;
- count enable and synchronous parallel load;
- terminal-count and wrap flags;
- a Gray-coded view of the count.

It sits in the lab designs as the general-purpose sequence source driving displays and test sequencers.

## Interface
- WIDTH, 3, number of T flip-flops / count bits; legal range 1..16
- MODULUS, 2**WIDTH, count range is 0..MODULUS-1; legal range 2..2**WIDTH
- CLK  input  1  rising-edge clock
- RST_N  input  1  asynchronous, active-low reset
- EN  input  1  count enable; when low the count holds
- UP  input  1  direction: 1 = count up, 0 = count down
- LOAD  input  1  synchronous parallel load; has priority over EN
- D  input  WIDTH  load value
- Q  output  WIDTH  registered count (the T flip-flop outputs)
- T  output  WIDTH  combinational toggle vector that will be applied at the next rising edge
- G  output  WIDTH  combinational Gray code of Q, Q ^ (Q >> 1)
- TC  output  1  combinational terminal count
- WRAP  output  1  registered one-cycle pulse after a wrap-around

## Operation
- Storage: Q[i] is a T flip-flop. On each rising CLK edge, Q[i] <= Q[i] ^ T[i]. No other path updates Q.
- T vector: T = Qn ^ Q, where Qn is the next count chosen by the priority list below. T is all-zero whenever the count will not change.
- Next-count priority:
  1. LOAD=1: Qn = D. If D > MODULUS-1, Qn = MODULUS-1 (clamp).
  2. EN=1 and UP=1: Qn = Q+1. If Q == MODULUS-1, Qn = 0.
  3. EN=1 and UP=0: Qn = Q-1. If Q == 0, Qn = MODULUS-1.
  4. Otherwise: Qn = Q.
- Out-of-range states: if Q > MODULUS-1 (reachable only through a glitch), the next enabled count step forces Qn = 0.
- Arithmetic: all arithmetic is unsigned, WIDTH bits, and never uses the natural 2**WIDTH overflow. For MODULUS == 2**WIDTH this is identical to natural binary wrap.
- TC = EN & ~LOAD & ((UP & Q == MODULUS-1) | (~UP & Q == 0)).
- WRAP: registered copy of TC. It is high for exactly the cycle following a wrapping edge.
- G: pure function of Q, with no state.
- Direction change (UP toggled while EN=1): takes effect at the next edge. There is no dead cycle.
- LOAD with EN=0: the load still happens.
- LOAD while TC would otherwise be set: TC=0, and WRAP is low on the following cycle.

## Timing
- Reset: RST_N low forces Q=0 and WRAP=0 immediately, without waiting for CLK. While RST_N is held low, T, G and TC follow combinationally from Q=0.
- Reset release: the first edge that can change Q is the first rising CLK edge with RST_N high.
- Reset mid-count: asserting RST_N at any point discards the current count and any LOAD in the same cycle. Q reads 0 within the reset propagation delay.
- Latency:
  - EN, UP, LOAD and D are sampled at a rising edge; Q reflects them after that edge (1 cycle).
  - T, G and TC are valid in the same cycle as their inputs.
  - WRAP lags TC by 1 cycle.
- Setup: inputs must be stable before the rising edge. The block has no internal synchronisers.

## Test plan
- Basic up-count, WIDTH=3, MODULUS=8, EN=1, UP=1, period 20 ns, 10 edges after reset release:
  - Q sequence: 0,1,2,3,4,5,6,7,0,1.
  - T sequence: 001,011,001,111,... (111 at Q=3 and Q=7).
  - TC high only at Q=7; WRAP high in the cycle Q=0 follows 7.
- Modulus and down-count, WIDTH=4, MODULUS=10:
  - Up from 0: Q reaches 9 and then 0, never 10. TC is high at Q=9.
  - Switch to UP=0 at Q=2: Q goes 1, 0, 9, 8. TC is high at Q=0, WRAP pulses after the 0→9 step.
- Load, WIDTH=4, MODULUS=10:
  - LOAD=1, D=5 with EN=0: Q=5 after one edge.
  - LOAD=1, D=13: Q=9 (clamp).
  - LOAD=1 at Q=9 with UP=1, D=3: Q=3, TC=0 that cycle, no WRAP pulse.
- Hold: EN=0, LOAD=0 for 5 edges at Q=6 → Q stays 6, T=0000, TC=0, G=0101.
- Asynchronous reset: drive RST_N low 3 ns after an edge with Q=6 → Q=0 and WRAP=0 before the next edge. Hold reset across 2 edges; Q stays 0. Release and count resumes from 0→1 at the first edge.
- Gray view, WIDTH=3: across a full up-count, G follows 000,001,011,010,110,111,101,100, with exactly one bit changing per step including the 7→0 wrap.

Source files
------------

// File: rtl/tff_updown_counter.sv
// Up/down modulus counter built from WIDTH toggle flip-flops.
// The toggle vector T is exported so the per-bit toggle pattern can be
// observed next to the count. Next count is chosen by priority:
// LOAD (clamped to MODULUS-1), then EN with direction UP, else hold.
// TC flags the step that will wrap, WRAP is its registered copy, and
// G is a Gray-coded view of Q.
module tff_updown_counter #(
  parameter int WIDTH   = 3,
  parameter int MODULUS = 2 ** WIDTH
) (
  input  logic             CLK,
  input  logic             RST_N,
  input  logic             EN,
  input  logic             UP,
  input  logic             LOAD,
  input  logic [WIDTH-1:0] D,
  output logic [WIDTH-1:0] Q,
  output logic [WIDTH-1:0] T,
  output logic [WIDTH-1:0] G,
  output logic             TC,
  output logic             WRAP
);

  // Highest legal count; all wrap decisions compare against this
  // rather than relying on natural 2**WIDTH overflow.
  localparam logic [WIDTH-1:0] CNT_MAX = WIDTH'(MODULUS - 1);
  localparam logic [WIDTH-1:0] ONE     = WIDTH'(1);

  logic [WIDTH-1:0] q_next;

  // Next-count selection; an out-of-range Q is forced to 0 on any enabled step.
  always_comb begin
    q_next = Q;
    if (LOAD) begin
      q_next = (D > CNT_MAX) ? CNT_MAX : D;
    end else if (EN) begin
      if (Q > CNT_MAX) begin
        q_next = '0;
      end else if (UP) begin
        q_next = (Q == CNT_MAX) ? '0 : Q + ONE;
      end else begin
        q_next = (Q == '0) ? CNT_MAX : Q - ONE;
      end
    end
  end

  // Toggle enables, terminal count and Gray view are pure functions of state and inputs.
  always_comb begin
    T  = q_next ^ Q;
    G  = Q ^ (Q >> 1);
    TC = EN & ~LOAD & ((UP & (Q == CNT_MAX)) | (~UP & (Q == '0)));
  end

  // T flip-flop bank: each bit only ever toggles under its own enable.
  always_ff @(posedge CLK or negedge RST_N) begin
    if (!RST_N) begin
      Q <= '0;
    end else begin
      for (int i = 0; i < WIDTH; i++) begin
        Q[i] <= Q[i] ^ T[i];
      end
    end
  end

  // Wrap pulse: high for the single cycle after a wrapping edge.
  always_ff @(posedge CLK or negedge RST_N) begin
    if (!RST_N) begin
      WRAP <= 1'b0;
    end else begin
      WRAP <= TC;
    end
  end

endmodule
